rr_reg_write_arbiter: RTL and testbench
=======================================

// Module: rr_reg_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing one WIDTH-bit async-reset D-register write port among NREQ requesters.
//   Grants are one-hot and registered. q is the shared flip-flop bank. Requesters see a req/gnt handshake.
//   Sits in front of the d/q register datapath wherever several producers must update one register.
// PARAMETERS
//   NREQ      4     number of requesters (>=2)
//   WIDTH     8     register data width
//   RST_VAL   0     value loaded into q on reset
//   MAX_LOCK  4     max consecutive writes per locked grant (used only with LOCK_EN, >=1)
// PORTS
//   clk      in   1            clock, rising edge
//   rst      in   1            asynchronous, active-low reset
//   req      in   NREQ         per-requester write request; hold high until write done
//   wdata    in   NREQ*WIDTH   requester i data in bits [i*WIDTH +: WIDTH]
//   lock     in   NREQ         per-requester lock request; port exists only with LOCK_EN
//   gnt      out  NREQ         one-hot grant, registered
//   q        out  WIDTH        shared register output
//   wr_done  out  1            1-cycle pulse: q was written on the previous edge
//   owner    out  clog2(NREQ)  index of the requester that last wrote q
// BEHAVIOUR
//   Reset (rst=0, async, immediate):
//     state=IDLE; gnt=0; q=RST_VAL; wr_done=0; owner=0; last=NREQ-1, so the first search starts at 0.
//   Priority pointer ptr = (last+1) mod NREQ.
//   Winner = first i with req[i]=1, scanning ptr, ptr+1, ... with wrap.
//   FSM, 2 states:
//     IDLE : gnt=0. If |req, latch winner w, set gnt=onehot(w), go to GRANT. Otherwise stay.
//     GRANT: gnt=onehot(w). At the closing edge:
//            - req[w]=1: q<=wdata[w]; owner<=w; last<=w; wr_done<=1 (next cycle only); go to IDLE.
//            - req[w]=0 (abort): no write; q, owner and last are unchanged; wr_done stays 0; go to IDLE.
//   Latency: req rises before edge k -> gnt high after edge k -> q updated at edge k+1 -> wr_done high after edge k+1.
//   Throughput: 1 write per 2 cycles. The mandatory IDLE cycle between grants lets gnt fall.
//   gnt is never multi-hot and never high in IDLE. Requests arriving during GRANT wait for the next IDLE.
//   Simultaneous requests: resolved only by round-robin order. A requester that just wrote has lowest priority next.
//   Wrap-around: the pointer wraps from NREQ-1 to 0. No starvation: any held req is granted within NREQ grants.
//   wdata is sampled only at the GRANT closing edge. Other requesters' wdata is ignored.
//   Async reset mid-GRANT: the pending write is dropped. All outputs take their reset values without waiting for a clock edge.
// CONFIGURATION
//   LOCK_EN defined:
//     The lock port exists. At the GRANT closing edge with req[w]=1 and lock[w]=1 and fewer than MAX_LOCK writes so far:
//     write as normal (wr_done=1) and stay in GRANT with the same w, so 1 write per cycle.
//     The MAX_LOCK-th consecutive write, or lock[w]=0, returns to IDLE. A burst counter resets on entry to GRANT.
//     An abort (req[w]=0) ends the burst with no write.
//   LOCK_EN undefined:
//     No lock port and no burst counter. GRANT always exits to IDLE after 1 cycle.
// TESTING (NREQ=4, WIDTH=8, RST_VAL=0, MAX_LOCK=4)
//   1. rst=0 then 1 with req=0 -> q=0x00, gnt=0000, wr_done=0, owner=0. All hold with no req.
//   2. req=0100, wdata[2]=0xA5 held -> gnt=0100 for 1 cycle; q=0xA5, wr_done pulse, owner=2; then gnt=0000.
//   3. req=1111 held, wdata[i]=0x10+i -> grant order 0,1,2,3,0. q steps 0x10,0x11,0x12,0x13,0x10, one write per 2 cycles.
//   4. req[1] drops during its GRANT -> q unchanged, no wr_done. Re-raised req[1] with req[3] -> 1 granted first.
//   5. rst low mid-GRANT (between edges) -> gnt=0000 and q=0x00 immediately. First grant after release goes to req 0 if requesting.
//   6. LOCK_EN: req=1001, lock[3]=1 with ptr=3 -> 4 consecutive writes by 3, then IDLE, then 0 granted.
//      Without LOCK_EN, the same stimulus alternates 3,0.

Source files
------------

// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter: round-robin arbiter sharing one WIDTH-bit register write port among NREQ requesters.
// Define LOCK_EN to add the lock port and MAX_LOCK-bounded burst writes.
module rr_reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int MAX_LOCK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
`ifdef LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    wr_done,
    output logic [$clog2(NREQ)-1:0] owner
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic [IW-1:0] last, w, ptr, winner;
    logic stay;
    int j;
    assign ptr = (last == IW'(NREQ-1)) ? '0 : last + 1'b1;
    // Scan from the far end so the requester closest to ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        j = 0;
        for (int k = NREQ-1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            winner = req[j] ? IW'(j) : winner;
        end
    end
`ifdef LOCK_EN
    localparam int CW = $clog2(MAX_LOCK+1);
    logic [CW-1:0] cnt;
    assign stay = req[w] && lock[w] && (cnt + 1'b1 < CW'(MAX_LOCK));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (state == IDLE) cnt <= '0;
        else if (req[w]) cnt <= cnt + 1'b1;
    end
`else
    assign stay = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb state_nx = (state == IDLE) ? (|req ? GRANT : IDLE) : (stay ? GRANT : IDLE);
    always_comb gnt = (state == GRANT) ? NREQ'(1) << w : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= RST_VAL;
            owner   <= '0;
            last    <= IW'(NREQ-1);
            w       <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= (state == GRANT) && req[w];
            if (state == IDLE && |req) w <= winner;
            if (state == GRANT && req[w]) begin
                q     <= wdata[int'(w)*WIDTH +: WIDTH];
                owner <= w;
                last  <= w;
            end
        end
    end
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// tb_rr_reg_write_arbiter: directed and randomized checks of rr_reg_write_arbiter against a behavioural model.
// Follows LOCK_EN the same way the design does.
module tb_rr_reg_write_arbiter;
    localparam int NREQ = 4, WIDTH = 8, MAX_LOCK = 4;
    logic clk = 0, rst;
    logic [NREQ-1:0] req;
    logic [NREQ*WIDTH-1:0] wdata;
`ifdef LOCK_EN
    logic [NREQ-1:0] lock;
`endif
    logic [NREQ-1:0] gnt;
    logic [WIDTH-1:0] q;
    logic wr_done;
    logic [1:0] owner;
    int checks = 0, errors = 0;

    rr_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RST_VAL(8'h00), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
`ifdef LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .q(q), .wr_done(wr_done), .owner(owner));

    always #5 clk = ~clk;

    // Model: transaction-level view of who holds the port and what the register holds.
    bit m_grant, m_wd;
    int m_w, m_last, m_owner, m_cnt;
    logic [WIDTH-1:0] m_q;

    task automatic m_reset();
        m_grant = 0; m_wd = 0; m_q = 0; m_owner = 0; m_last = NREQ-1; m_w = 0; m_cnt = 0;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++)
            if (req[(m_last + 1 + k) % NREQ]) return (m_last + 1 + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] m_gnt();
        return m_grant ? NREQ'(1 << m_w) : '0;
    endfunction

    task automatic m_edge();
        m_wd = 0;
        if (!m_grant) begin
            if (req != 0) begin m_w = m_winner(); m_grant = 1; m_cnt = 0; end
        end else begin
            m_grant = 0;
            if (req[m_w]) begin
                m_q = wdata[m_w*WIDTH +: WIDTH]; m_owner = m_w; m_last = m_w; m_wd = 1; m_cnt++;
`ifdef LOCK_EN
                m_grant = lock[m_w] && m_cnt < MAX_LOCK;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0; req = 0;
`ifdef LOCK_EN
        lock = 0;
`endif
        #1 m_reset();
        @(negedge clk) rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; req = 0; wdata = 0;
`ifdef LOCK_EN
        lock = 0;
`endif
        m_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({gnt, q, wr_done, owner} !== 15'h0) begin
            errors++; $display("FAIL reset_low got gnt=%b q=%h wd=%b own=%0d exp all zero", gnt, q, wr_done, owner);
        end
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({gnt, q, wr_done, owner} !== 15'h0) begin
                errors++; $display("FAIL reset_hold got gnt=%b q=%h wd=%b own=%0d exp all zero", gnt, q, wr_done, owner);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0100; wdata = {$urandom, $urandom}; wdata[2*WIDTH +: WIDTH] = 8'hA5;
        step();
        checks++;
        if (gnt !== 4'b0100 || wr_done !== 0) begin
            errors++; $display("FAIL single_gnt got gnt=%b wd=%b exp 0100 0", gnt, wr_done);
        end
        step();
        checks++;
        if ({gnt, q, wr_done, owner} !== {4'b0000, 8'hA5, 1'b1, 2'd2}) begin
            errors++; $display("FAIL single_write got gnt=%b q=%h wd=%b own=%0d exp 0000 a5 1 2", gnt, q, wr_done, owner);
        end
        req = 0;
        step();
        checks++;
        if ({gnt, q, wr_done, owner} !== {m_gnt(), m_q, m_wd, 2'(m_owner)} || wr_done !== 0) begin
            errors++; $display("FAIL single_after got gnt=%b q=%h wd=%b own=%0d exp %b %h 0 %0d", gnt, q, wr_done, owner, m_gnt(), m_q, m_owner);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111; wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (gnt !== 4'(1 << (n % 4)) || wr_done !== 0) begin
                errors++; $display("FAIL rr_gnt%0d got gnt=%b wd=%b exp %b 0", n, gnt, wr_done, 4'(1 << (n % 4)));
            end
            step();
            checks++;
            if ({gnt, q, wr_done, owner} !== {4'b0, 8'(8'h10 + n % 4), 1'b1, 2'(n % 4)}) begin
                errors++; $display("FAIL rr_write%0d got gnt=%b q=%h wd=%b own=%0d exp 0000 %h 1 %0d", n, gnt, q, wr_done, owner, 8'h10 + n % 4, n % 4);
            end
        end
        req = 0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0010; wdata = {$urandom, $urandom};
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_gnt got %b exp 0010", gnt); end
        req = 0;
        step();
        checks++;
        if ({gnt, q, wr_done, owner} !== 15'h0) begin
            errors++; $display("FAIL abort_nowrite got gnt=%b q=%h wd=%b own=%0d exp all zero", gnt, q, wr_done, owner);
        end
        req = 4'b1010;
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_regrant got %b exp 0010", gnt); end
        step();
        checks++;
        if ({q, wr_done, owner} !== {wdata[WIDTH +: WIDTH], 1'b1, 2'd1}) begin
            errors++; $display("FAIL abort_write got q=%h wd=%b own=%0d exp %h 1 1", q, wr_done, owner, wdata[WIDTH +: WIDTH]);
        end
        req = 0;
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100; wdata = {$urandom, $urandom}; wdata[2*WIDTH +: WIDTH] = 8'h5A;
        step(); step(); step();
        checks++;
        if (gnt !== 4'b0100 || q !== 8'h5A) begin errors++; $display("FAIL mid_setup got gnt=%b q=%h exp 0100 5a", gnt, q); end
        #2 rst = 0;
        #1;
        checks++;
        if ({gnt, q, wr_done, owner} !== 15'h0) begin
            errors++; $display("FAIL mid_async got gnt=%b q=%h wd=%b own=%0d exp all zero", gnt, q, wr_done, owner);
        end
        m_reset();
        req = 4'b1111;
        @(negedge clk) rst = 1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first got %b exp 0001", gnt); end
        req = 0;
        step(); step();
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] eg [6];
        bit ew [6];
        do_reset();
        req = 4'b0100; wdata = {$urandom, $urandom};
        step(); step();
        req = 4'b1001;
`ifdef LOCK_EN
        lock = 4'b1000;
        eg = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        ew = '{0, 1, 1, 1, 1, 0};
`else
        eg = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        ew = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (gnt !== eg[i] || wr_done !== ew[i]) begin
                errors++; $display("FAIL lock_step%0d got gnt=%b wd=%b exp %b %b", i, gnt, wr_done, eg[i], ew[i]);
            end
        end
        req = 0;
        step(); step();
    endtask

    task automatic test_random();
        do_reset();
        wdata = {$urandom, $urandom};
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) req = 4'($urandom);
            wdata = {$urandom, $urandom};
`ifdef LOCK_EN
            lock = 4'($urandom);
`endif
            step();
            checks++;
            if ({gnt, q, wr_done, owner} !== {m_gnt(), m_q, m_wd, 2'(m_owner)} || !$onehot0(gnt)) begin
                errors++; $display("FAIL rand%0d got gnt=%b q=%h wd=%b own=%0d exp %b %h %b %0d", i, gnt, q, wr_done, owner, m_gnt(), m_q, m_wd, m_owner);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_reset_mid_grant();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
